or1200_keccak_cust5_resp: RTL and testbench

OR1200_KECCAK_CUST5_RESP -- requirements
Module: or1200_keccak_cust5_resp

---
 rtl/or1200_keccak_pkg.sv | 42 ++++
 rtl/or1200_keccak_msgbuf.sv | 44 ++++
 rtl/or1200_keccak_cust5_resp.sv | 143 ++++++++++++++
 tb/tb_or1200_keccak_cust5_resp.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_keccak_pkg.sv
// Shared types for the l.cust5 Keccak command front end.
// Op encodings, FSM states and default buffer geometry.
package or1200_keccak_pkg;

  localparam int RATE_WORDS_DEF   = 34;
  localparam int DIGEST_WORDS_DEF = 16;

  localparam logic [4:0] OP_START  = 5'b00100;
  localparam logic [4:0] OP_MIDDLE = 5'b00010;
  localparam logic [4:0] OP_END    = 5'b00001;
  localparam logic [4:0] OP_STORE  = 5'b01000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_HASH,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic start;
    logic middle;
    logic fin;
    logic store;
    logic bad;
  } op_dec_t;

  // Exactly one field is set for any op value.
  function automatic op_dec_t decode_op(input logic [4:0] op);
    op_dec_t d;
    d = '0;
    unique case (op)
      OP_START:  d.start  = 1'b1;
      OP_MIDDLE: d.middle = 1'b1;
      OP_END:    d.fin    = 1'b1;
      OP_STORE:  d.store  = 1'b1;
      default:   d.bad    = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/or1200_keccak_msgbuf.sv
// Message word buffer for the absorb phase.
// Load restarts it with one word; push appends while not full.
module or1200_keccak_msgbuf
  import or1200_keccak_pkg::*;
#(
  parameter int RATE_WORDS = RATE_WORDS_DEF,
  parameter int CW = $clog2(RATE_WORDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    push,
  input  logic [31:0]             data,
  output logic [32*RATE_WORDS-1:0] msg,
  output logic [CW-1:0]           count,
  output logic                    full
);

  logic [31:0] words [RATE_WORDS];

  assign full = (count == CW'(RATE_WORDS));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      for (int i = 0; i < RATE_WORDS; i++)
        words[i] <= '0;
    end else if (load) begin
      count <= CW'(1);
      for (int i = 0; i < RATE_WORDS; i++)
        words[i] <= (i == 0) ? data : '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
      for (int i = 0; i < RATE_WORDS; i++)
        if (CW'(i) == count)
          words[i] <= data;
    end
  end

  for (genvar g = 0; g < RATE_WORDS; g++) begin : g_msg
    assign msg[32*g +: 32] = words[g];
  end

endmodule

// File: rtl/or1200_keccak_cust5_resp.sv
// l.cust5 command FSM for the Keccak unit: absorb,
// hand off to the permutation core, and answer stores.
module or1200_keccak_cust5_resp
  import or1200_keccak_pkg::*;
#(
  parameter int RATE_WORDS   = RATE_WORDS_DEF,
  parameter int DIGEST_WORDS = DIGEST_WORDS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  input  logic [4:0]                cmd_op,
  input  logic [5:0]                cmd_limm,
  input  logic [31:0]               cmd_data,
  output logic                      cmd_stall,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_data,
  output logic                      core_start,
  output logic [32*RATE_WORDS-1:0]  core_msg,
  output logic [5:0]                core_len,
  input  logic                      core_done,
  input  logic [32*DIGEST_WORDS-1:0] core_digest,
  output logic                      err
);

  localparam int CW = $clog2(RATE_WORDS + 1);

  state_t  state_q, state_d;
  op_dec_t dec;

  logic          accept;
  logic          in_abs;
  logic          hash_done;
  logic          limm_ok;
  logic          full;
  logic          load, push, go_hash, rd;
  logic          set_err, clr_err;
  logic [CW-1:0] count;
  logic [31:0]   rd_word;

  logic [32*DIGEST_WORDS-1:0] digest_q;

  assign dec       = decode_op(cmd_op);
  assign cmd_stall = cmd_valid & (state_q == ST_HASH);
  assign accept    = cmd_valid & ~cmd_stall;
  assign in_abs    = (state_q == ST_ABSORB);
  assign hash_done = (state_q == ST_HASH) & core_done;
  assign limm_ok   = {26'd0, cmd_limm} < 32'(DIGEST_WORDS);
  assign core_len  = 6'(count);

  or1200_keccak_msgbuf #(
    .RATE_WORDS(RATE_WORDS)
  ) u_msgbuf (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .push (push),
    .data (cmd_data),
    .msg  (core_msg),
    .count(count),
    .full (full)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (1'b1)
        dec.start: state_d = ST_ABSORB;
        dec.fin:
          if (in_abs)
            state_d = full ? ST_IDLE : ST_HASH;
        default: ;
      endcase
    end else if (hash_done) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    load    = 1'b0;
    push    = 1'b0;
    go_hash = 1'b0;
    rd      = 1'b0;
    set_err = 1'b0;
    clr_err = 1'b0;
    if (accept) begin
      unique case (1'b1)
        dec.start: begin
          load    = 1'b1;
          clr_err = 1'b1;
        end
        dec.middle:
          if (in_abs && !full) push = 1'b1;
          else                 set_err = 1'b1;
        dec.fin:
          if (in_abs && !full) begin
            push    = 1'b1;
            go_hash = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        dec.store: begin
          rd      = 1'b1;
          set_err = ~limm_ok;
        end
        dec.bad: set_err = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DIGEST_WORDS; i++)
      if (cmd_limm == 6'(i))
        rd_word = digest_q[32*i +: 32];
  end

  // Commands are never accepted in HASH, so the
  // digest capture cannot collide with a store.
  always_ff @(posedge clk) begin
    if (!rst) begin
      core_start <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      err        <= 1'b0;
      digest_q   <= '0;
    end else begin
      core_start <= go_hash;
      rsp_valid  <= rd;
      rsp_data   <= (rd && limm_ok) ? rd_word : '0;
      if (clr_err)      err <= 1'b0;
      else if (set_err) err <= 1'b1;
      if (hash_done) digest_q <= core_digest;
    end
  end

endmodule

// File: tb/tb_or1200_keccak_cust5_resp.sv
// Bench for the l.cust5 Keccak front end: directed
// scenarios plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_or1200_keccak_cust5_resp;
  import or1200_keccak_pkg::*;

  localparam int RW = RATE_WORDS_DEF;
  localparam int DW = DIGEST_WORDS_DEF;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [4:0]       cmd_op = '0;
  logic [5:0]       cmd_limm = '0;
  logic [31:0]      cmd_data = '0;
  logic             cmd_stall;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic             core_start;
  logic [32*RW-1:0] core_msg;
  logic [5:0]       core_len;
  logic             core_done = 1'b0;
  logic [32*DW-1:0] core_digest = '0;
  logic             err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  or1200_keccak_cust5_resp dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_limm   (cmd_limm),
    .cmd_data   (cmd_data),
    .cmd_stall  (cmd_stall),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .core_start (core_start),
    .core_msg   (core_msg),
    .core_len   (core_len),
    .core_done  (core_done),
    .core_digest(core_digest),
    .err        (err)
  );

  // Reference model: message is a queue, digest an array.
  state_t      m_st = ST_IDLE;
  logic [31:0] m_msg[$];
  logic [31:0] m_dig[DW];
  bit          m_err, m_cs, m_rv;
  logic [31:0] m_rd;

  task automatic model_step();
    m_cs = 0;
    m_rv = 0;
    m_rd = '0;
    if (!rst) begin
      m_st = ST_IDLE;
      m_msg.delete();
      m_err = 0;
      foreach (m_dig[k]) m_dig[k] = '0;
    end else if (cmd_valid && m_st != ST_HASH) begin
      case (cmd_op)
        OP_START: begin
          m_msg.delete();
          m_msg.push_back(cmd_data);
          m_err = 0;
          m_st = ST_ABSORB;
        end
        OP_MIDDLE:
          if (m_st == ST_ABSORB && m_msg.size() < RW)
            m_msg.push_back(cmd_data);
          else
            m_err = 1;
        OP_END:
          if (m_st != ST_ABSORB) m_err = 1;
          else if (m_msg.size() < RW) begin
            m_msg.push_back(cmd_data);
            m_st = ST_HASH;
            m_cs = 1;
          end else begin
            m_err = 1;
            m_st = ST_IDLE;
          end
        OP_STORE: begin
          m_rv = 1;
          if (cmd_limm < DW) m_rd = m_dig[cmd_limm];
          else m_err = 1;
        end
        default: m_err = 1;
      endcase
    end else if (m_st == ST_HASH && core_done) begin
      foreach (m_dig[k]) m_dig[k] = core_digest[32*k +: 32];
      m_st = ST_DONE;
    end
  endtask

  function automatic logic [32*RW-1:0] exp_msg();
    logic [32*RW-1:0] v;
    v = '0;
    foreach (m_msg[k]) v[32*k +: 32] = m_msg[k];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op,
                      input logic [5:0] limm,
                      input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_limm  = limm;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({cmd_stall, rsp_valid, core_start, err} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags got=%b exp=0000",
               {cmd_stall, rsp_valid, core_start, err});
    end
    n_chk++;
    if (rsp_data !== 0 || core_len !== 0 || core_msg !== '0) begin
      n_err++;
      $display("FAIL reset_data rsp=%h len=%0d exp=0",
               rsp_data, core_len);
    end
    n_chk++;
    if (dut.state_q !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q);
    end
    rst = 1'b1;
  endtask

  task automatic test_absorb();
    logic [32*RW-1:0] exp;
    bit early;
    early = 0;
    send(OP_START, 0, 1);
    if (core_start !== 1'b0) early = 1;
    for (int d = 2; d <= 6; d++) begin
      send(OP_MIDDLE, 0, d);
      if (core_start !== 1'b0) early = 1;
    end
    n_chk++;
    if (early) begin
      n_err++;
      $display("FAIL absorb_early_start got=1 exp=0");
    end
    send(OP_END, 0, 7);
    n_chk++;
    if (core_start !== 1'b1) begin
      n_err++;
      $display("FAIL absorb_start got=%b exp=1", core_start);
    end
    n_chk++;
    if (core_len !== 6'd7) begin
      n_err++;
      $display("FAIL absorb_len got=%0d exp=7", core_len);
    end
    exp = '0;
    for (int i = 0; i < 7; i++) exp[32*i +: 32] = 32'(i + 1);
    n_chk++;
    if (core_msg !== exp) begin
      n_err++;
      $display("FAIL absorb_msg got=%h exp=%h",
               core_msg[255:0], exp[255:0]);
    end
    tick();
    n_chk++;
    if (core_start !== 1'b0) begin
      n_err++;
      $display("FAIL absorb_pulse got=%b exp=0", core_start);
    end
  endtask

  task automatic test_hash_stall();
    int bad;
    bad = 0;
    cmd_valid = 1'b1;
    cmd_op    = OP_STORE;
    cmd_limm  = 6'd15;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (cmd_stall !== 1'b1 || rsp_valid !== 1'b0) bad++;
      tick();
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hash_stall bad_cycles=%0d exp=0", bad);
    end
    for (int k = 0; k < DW; k++)
      core_digest[32*k +: 32] = 32'(k) + 32'h100;
    core_done = 1'b1;
    #1;
    n_chk++;
    if (cmd_stall !== 1'b1) begin
      n_err++;
      $display("FAIL hash_done_stall got=%b exp=1", cmd_stall);
    end
    tick();
    core_done = 1'b0;
    #1;
    n_chk++;
    if (cmd_stall !== 1'b0 || dut.state_q !== ST_DONE) begin
      n_err++;
      $display("FAIL hash_release stall=%b st=%0d exp=0/DONE",
               cmd_stall, dut.state_q);
    end
    tick();
    cmd_valid = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h10F) begin
      n_err++;
      $display("FAIL hash_store v=%b d=%h exp=1/0000010f",
               rsp_valid, rsp_data);
    end
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hash_rsp_drop got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_errors();
    send(OP_START, 0, 32'hA0);
    for (int i = 0; i < 33; i++) send(OP_MIDDLE, 0, 32'hB00 + 32'(i));
    n_chk++;
    if (err !== 1'b0 || core_len !== 6'd34 ||
        core_msg[32*33 +: 32] !== 32'hB20) begin
      n_err++;
      $display("FAIL err_fill err=%b len=%0d w33=%h exp=0/34/b20",
               err, core_len, core_msg[32*33 +: 32]);
    end
    for (int i = 0; i < 2; i++) send(OP_MIDDLE, 0, 32'hDEAD);
    n_chk++;
    if (err !== 1'b1 || core_len !== 6'd34) begin
      n_err++;
      $display("FAIL err_overflow err=%b len=%0d exp=1/34",
               err, core_len);
    end
    send(OP_END, 0, 32'hBEEF);
    n_chk++;
    if (core_start !== 1'b0 || dut.state_q !== ST_IDLE) begin
      n_err++;
      $display("FAIL err_end cs=%b st=%0d exp=0/IDLE",
               core_start, dut.state_q);
    end
    send(OP_START, 0, 32'h77);
    n_chk++;
    if (err !== 1'b0 || core_len !== 6'd1 ||
        core_msg !== {{(32*RW-32){1'b0}}, 32'h77}) begin
      n_err++;
      $display("FAIL err_restart err=%b len=%0d w1=%h exp=0/1/0",
               err, core_len, core_msg[63:32]);
    end
    send(OP_STORE, 6'd16, 0);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_data !== 0 || err !== 1'b1) begin
      n_err++;
      $display("FAIL err_store v=%b d=%h err=%b exp=1/0/1",
               rsp_valid, rsp_data, err);
    end
  endtask

  task automatic test_ignored();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    send(OP_END, 0, 5);
    n_chk++;
    if (err !== 1'b1 || dut.state_q !== ST_IDLE ||
        core_start !== 1'b0 || core_len !== 0) begin
      n_err++;
      $display("FAIL ign_end err=%b st=%0d exp=1/IDLE",
               err, dut.state_q);
    end
    send(OP_START, 0, 32'h55);
    n_chk++;
    if (err !== 1'b0 || core_len !== 6'd1 ||
        dut.state_q !== ST_ABSORB) begin
      n_err++;
      $display("FAIL ign_start err=%b len=%0d exp=0/1",
               err, core_len);
    end
    send(5'b00011, 0, 32'h66);
    n_chk++;
    if (err !== 1'b1 || core_len !== 6'd1) begin
      n_err++;
      $display("FAIL ign_badop err=%b len=%0d exp=1/1",
               err, core_len);
    end
  endtask

  task automatic test_reset_in_hash();
    send(OP_START, 0, 32'h11);
    send(OP_END, 0, 32'h22);
    n_chk++;
    if (dut.state_q !== ST_HASH || core_start !== 1'b1) begin
      n_err++;
      $display("FAIL rh_enter st=%0d cs=%b exp=HASH/1",
               dut.state_q, core_start);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_chk++;
    if ({cmd_stall, rsp_valid, core_start, err} !== 4'b0 ||
        rsp_data !== 0 || core_len !== 0 || core_msg !== '0 ||
        dut.state_q !== ST_IDLE) begin
      n_err++;
      $display("FAIL rh_reset st=%0d len=%0d cs=%b exp=IDLE/0/0",
               dut.state_q, core_len, core_start);
    end
    for (int k = 0; k < DW; k++)
      core_digest[32*k +: 32] = 32'hCAFE0000 + 32'(k);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    n_chk++;
    if (dut.state_q !== ST_IDLE) begin
      n_err++;
      $display("FAIL rh_done st=%0d exp=IDLE", dut.state_q);
    end
    send(OP_STORE, 0, 0);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_data !== 0) begin
      n_err++;
      $display("FAIL rh_store v=%b d=%h exp=1/0",
               rsp_valid, rsp_data);
    end
  endtask

  task automatic test_random();
    int p;
    bit exp_stall;
    logic [32*RW-1:0] em;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      cmd_valid = ($urandom_range(0, 9) < 7);
      p = $urandom_range(0, 19);
      if (p < 2)       cmd_op = OP_START;
      else if (p < 11) cmd_op = OP_MIDDLE;
      else if (p < 14) cmd_op = OP_END;
      else if (p < 17) cmd_op = OP_STORE;
      else             cmd_op = 5'($urandom);
      cmd_limm = 6'($urandom_range(0, 20));
      cmd_data = $urandom;
      core_done = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < DW; k++)
        core_digest[32*k +: 32] = $urandom;
      exp_stall = cmd_valid && (m_st == ST_HASH);
      #1;
      n_chk++;
      if (cmd_stall !== exp_stall) begin
        n_err++;
        $display("FAIL rand_stall c=%0d got=%b exp=%b",
                 c, cmd_stall, exp_stall);
      end
      tick();
      n_chk++;
      if (core_start !== m_cs || rsp_valid !== m_rv ||
          rsp_data !== m_rd || err !== m_err) begin
        n_err++;
        $display("FAIL rand_out c=%0d got=%b%b %h %b exp=%b%b %h %b",
                 c, core_start, rsp_valid, rsp_data, err,
                 m_cs, m_rv, m_rd, m_err);
      end
      n_chk++;
      if (core_len !== 6'(m_msg.size()) || dut.state_q !== m_st) begin
        n_err++;
        $display("FAIL rand_len c=%0d len=%0d st=%0d exp=%0d/%0d",
                 c, core_len, dut.state_q, m_msg.size(), m_st);
      end
      em = exp_msg();
      n_chk++;
      if (core_msg !== em) begin
        n_err++;
        for (int w = RW - 1; w >= 0; w--)
          if (core_msg[32*w +: 32] !== em[32*w +: 32]) p = w;
        $display("FAIL rand_msg c=%0d word=%0d got=%h exp=%h",
                 c, p, core_msg[32*p +: 32], em[32*p +: 32]);
      end
    end
    cmd_valid = 1'b0;
    core_done = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_absorb();
    test_hash_stall();
    test_errors();
    test_ignored();
    test_reset_in_hash();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
